delay_path_prober: RTL

Launch-and-capture controller for the inverting delay-path chains used as delay sensors. It drives a chain's input with a single-cycle-registered transition and waits a programmable number of settle cycles. It then samples the chain output and compares it with the expected logic value. Over a burst of N launches it accumulates a mismatch count, which it reports through a valid/ready result handshake to the readout logic.

---
 rtl/delay_path_prober_if.sv | 31 +++
 rtl/delay_path_prober.sv | 122 ++++++++++++
 2 files changed

// File: rtl/delay_path_prober_if.sv
// Bundle of the burst-control and result signals of delay_path_prober.
//
// Handshake: the result transfers on the rising clock edge where
// result_valid && result_ready are both high. Once raised, result_valid
// stays high and error_count/sample_count stay stable until that transfer;
// result_ready may be driven freely and has no effect while result_valid is low.
interface delay_path_prober_if #(
  parameter int CNT_W    = 16,
  parameter int SETTLE_W = 4
);
  logic                start;
  logic [CNT_W-1:0]    num_samples;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic [CNT_W-1:0]    error_count;
  logic [CNT_W-1:0]    sample_count;

  // Readout / control side.
  modport master (
    output start, num_samples, settle_cycles, result_ready,
    input  busy, result_valid, error_count, sample_count
  );

  // The prober itself.
  modport slave (
    input  start, num_samples, settle_cycles, result_ready,
    output busy, result_valid, error_count, sample_count
  );
endinterface

// File: rtl/delay_path_prober.sv
// Launch-and-capture controller for delay-sensor chains. Each launch toggles
// the chain input, waits settle_cycles+1 cycles, then compares the registered
// chain output with the expected level. A burst of N launches yields a
// saturating mismatch count returned over a valid/ready handshake.
module delay_path_prober #(
  parameter int CNT_W     = 16,
  parameter int SETTLE_W  = 4,
  parameter int INVERTING = 0
) (
  input  logic                clk,
  input  logic                rst,
  delay_path_prober_if.slave  bus,
  output logic                launch,
  input  logic                capture,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic INV = (INVERTING != 0);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_launch;
  logic                r_capture_q;
  logic                r_busy;
  logic                r_valid;
  logic [CNT_W-1:0]    r_err;
  logic [CNT_W-1:0]    r_samp;
  logic [CNT_W-1:0]    r_n;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] r_cnt;

  logic                w_accept;
  logic                w_mismatch;
  logic [CNT_W-1:0]    w_samp_inc;

  assign w_accept   = (r_state == S_IDLE) && bus.start && (bus.num_samples != '0);
  assign w_mismatch = r_capture_q != (r_launch ^ INV);
  assign w_samp_inc = r_samp + ONE;

  // Next-state decode for the burst sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (w_samp_inc == r_n) ? S_DONE : S_LAUNCH;
      S_DONE:   if (r_valid && bus.result_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus busy/valid flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: capture sampling, launch toggle, settle countdown and counters.
  // capture_q has no synchronizer on purpose: the sampling window is the
  // measurement, so metastability resolves as a (counted) mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capture_q <= 1'b0;
      r_launch    <= 1'b0;
      r_err       <= '0;
      r_samp      <= '0;
      r_n         <= '0;
      r_settle    <= '0;
      r_cnt       <= '0;
    end else begin
      r_capture_q <= capture;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n      <= bus.num_samples;
            r_settle <= bus.settle_cycles;
            r_err    <= '0;
            r_samp   <= '0;
          end
        end
        S_LAUNCH: begin
          // Never restored between bursts, so edge polarity keeps alternating.
          r_launch <= ~r_launch;
          r_cnt    <= r_settle;
        end
        S_SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_SAMPLE: begin
          if (w_mismatch && (r_err != '1)) r_err <= r_err + ONE;
          r_samp <= w_samp_inc;
        end
        default: ;
      endcase
    end
  end

  assign launch           = r_launch;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.error_count  = r_err;
  assign bus.sample_count = r_samp;
  assign dbg_state        = r_state;

endmodule
